// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - interrupt controller: edge/level capture, masking, fixed priority, INTR/INTA handshake
module irq_controller #(
    parameter int         NUM_IRQ     = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_write,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic               intr,
    input  logic               inta,
    output logic [7:0]         vector,
    output logic               vector_valid,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_BASE = 2'd2;
    localparam logic [1:0] ADDR_EOI  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               intr_q, intr_d;
    logic [7:0]         vector_q, vector_d;
    logic               vector_valid_q, vector_valid_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [4:0]         base_q, base_d;

    logic               cand_found;
    logic [2:0]         cand_idx;
    logic               blocked;
    logic               eoi_found;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] ack_onehot;
    logic [NUM_IRQ-1:0] edge_set;

    // A line only qualifies if it outranks every line currently in service.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = 3'd0;
        blocked    = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_service_q[i]) begin
                blocked = 1'b1;
            end
            if (!blocked && !cand_found && pending_q[i] && !mask_q[i]) begin
                cand_found = 1'b1;
                cand_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        eoi_found = 1'b0;
        eoi_clr   = '0;
        if (cfg_write && (cfg_addr == ADDR_EOI)) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (!eoi_found && in_service_q[i]) begin
                    eoi_clr[i] = 1'b1;
                    eoi_found  = 1'b1;
                end
            end
        end
    end

    assign ack_fire = (state_q == ST_REQ) && inta && cand_found;

    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_onehot[i] = ack_fire && (cand_idx == 3'(i));
        end
    end

    assign edge_set = irq & ~irq_prev_q;

    always_comb begin
        irq_prev_d   = irq;
        in_service_d = (in_service_q & ~eoi_clr) | ack_onehot;
        pending_d    = pending_q;
        // Edge set beats the acknowledge clear when both land on one clock.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (edge_mode_q[i]) begin
                pending_d[i] = edge_set[i] | (pending_q[i] & ~ack_onehot[i]);
            end else begin
                pending_d[i] = irq[i];
            end
        end
    end

    always_comb begin
        mask_d      = mask_q;
        edge_mode_d = edge_mode_q;
        base_d      = base_q;
        if (cfg_write) begin
            case (cfg_addr)
                ADDR_MASK: mask_d      = cfg_wdata[NUM_IRQ-1:0];
                ADDR_EDGE: edge_mode_d = cfg_wdata[NUM_IRQ-1:0];
                ADDR_BASE: base_d      = cfg_wdata[7:3];
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        intr_d         = intr_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_found) begin
                    intr_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    intr_d         = 1'b0;
                    vector_valid_d = 1'b1;
                    state_d        = ST_RESP;
                    vector_d       = cand_found ? {base_q, cand_idx} : {base_q, 3'd7};
                end
            end
            ST_RESP: begin
                intr_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                intr_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            intr_q         <= 1'b0;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            pending_q      <= '0;
            in_service_q   <= '0;
            mask_q         <= '1;
            edge_mode_q    <= '1;
            irq_prev_q     <= '0;
            base_q         <= VECTOR_BASE[7:3];
        end else begin
            state_q        <= state_d;
            intr_q         <= intr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            pending_q      <= pending_d;
            in_service_q   <= in_service_d;
            mask_q         <= mask_d;
            edge_mode_q    <= edge_mode_d;
            irq_prev_q     <= irq_prev_d;
            base_q         <= base_d;
        end
    end

    assign intr         = intr_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign pending      = pending_q;
    assign in_service   = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller with a vector scoreboard
module tb_irq_controller;

    logic       clock;
    logic       reset;
    logic [7:0] irq;
    logic       cfg_write;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       intr;
    logic       inta;
    logic [7:0] vector;
    logic       vector_valid;
    logic [7:0] pending;
    logic [7:0] in_service;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    irq_controller #(.NUM_IRQ(8), .VECTOR_BASE(8'h20)) dut (
        .clock        (clock),
        .reset        (reset),
        .irq          (irq),
        .cfg_write    (cfg_write),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .intr         (intr),
        .inta         (inta),
        .vector       (vector),
        .vector_valid (vector_valid),
        .pending      (pending),
        .in_service   (in_service)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every vector_valid pulse must match the oldest expected vector.
    always @(negedge clock) begin
        if (vector_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_vector got=%h exp=none", vector);
            end else begin
                exp_v = exp_q.pop_front();
                if (vector !== exp_v) begin
                    errors++;
                    $display("FAIL sb_vector got=%h exp=%h", vector, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input logic [1:0] addr, input logic [7:0] data);
        cfg_write = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic ack(input logic [7:0] exp);
        inta = 1'b1;
        exp_q.push_back(exp);
        tick();
        inta = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq = 8'h00; cfg_write = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00; inta = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr got=%b exp=0", intr); end
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL rst_vector got=%h exp=00", vector); end
        checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL rst_vv got=%b exp=0", vector_valid); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending got=%h exp=00", pending); end
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL rst_in_service got=%h exp=00", in_service); end
    endtask

    task automatic test_single_edge();
        cfg(2'd0, 8'hFE);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL t1_pending got=%h exp=01", pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t1_intr_early got=%b exp=0", intr); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t1_intr got=%b exp=1", intr); end
        ack(8'h20);
        checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL t1_vv got=%b exp=1", vector_valid); end
        checks++; if (vector !== 8'h20) begin errors++; $display("FAIL t1_vector got=%h exp=20", vector); end
        checks++; if (in_service !== 8'h01) begin errors++; $display("FAIL t1_in_service got=%h exp=01", in_service); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL t1_pending_clr got=%h exp=00", pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t1_intr_resp got=%b exp=0", intr); end
        tick();
        checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL t1_vv_pulse got=%b exp=0", vector_valid); end
        cfg(2'd3, 8'h00);
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL t1_eoi got=%h exp=00", in_service); end
    endtask

    task automatic test_priority();
        cfg(2'd0, 8'h00);
        irq = 8'h24;
        tick();
        checks++; if (pending !== 8'h24) begin errors++; $display("FAIL t2_pending got=%h exp=24", pending); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t2_intr got=%b exp=1", intr); end
        ack(8'h22);
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL t2_is1 got=%h exp=04", in_service); end
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL t2_pending2 got=%h exp=20", pending); end
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t2_blocked got=%b exp=0", intr); end
        cfg(2'd3, 8'hA5);
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL t2_eoi got=%h exp=00", in_service); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t2_reassert got=%b exp=1", intr); end
        ack(8'h25);
        checks++; if (in_service !== 8'h20) begin errors++; $display("FAIL t2_is2 got=%h exp=20", in_service); end
        irq = 8'h00;
        tick();
        cfg(2'd3, 8'h00);
    endtask

    task automatic test_nesting();
        irq = 8'h08;
        tick(); tick();
        ack(8'h23);
        checks++; if (in_service !== 8'h08) begin errors++; $display("FAIL t3_is3 got=%h exp=08", in_service); end
        tick();
        irq = 8'h48;
        tick();
        checks++; if (pending !== 8'h40) begin errors++; $display("FAIL t3_pending6 got=%h exp=40", pending); end
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t3_low_blocked got=%b exp=0", intr); end
        irq = 8'h4A;
        tick(); tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t3_nest_intr got=%b exp=1", intr); end
        ack(8'h21);
        checks++; if (in_service !== 8'h0A) begin errors++; $display("FAIL t3_is_nest got=%h exp=0A", in_service); end
        tick();
        cfg(2'd3, 8'h00);
        checks++; if (in_service !== 8'h08) begin errors++; $display("FAIL t3_eoi_lowest got=%h exp=08", in_service); end
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t3_still_blocked got=%b exp=0", intr); end
        cfg(2'd3, 8'h00);
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t3_line6_intr got=%b exp=1", intr); end
        ack(8'h26);
        tick();
        cfg(2'd3, 8'h00);
        irq = 8'h00;
        tick();
        checks++; if (in_service !== 8'h00 || pending !== 8'h00) begin
            errors++; $display("FAIL t3_clean got=%h/%h exp=00/00", in_service, pending);
        end
    endtask

    task automatic test_spurious();
        irq = 8'h10;
        tick(); tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t4_intr got=%b exp=1", intr); end
        cfg(2'd0, 8'hFF);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t4_intr_held got=%b exp=1", intr); end
        ack(8'h27);
        checks++; if (vector !== 8'h27) begin errors++; $display("FAIL t4_vector got=%h exp=27", vector); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t4_intr_resp got=%b exp=0", intr); end
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL t4_is got=%h exp=00", in_service); end
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL t4_pending got=%h exp=10", pending); end
        irq = 8'h00;
        tick();
    endtask

    task automatic test_level();
        cfg(2'd1, 8'h00);
        cfg(2'd2, 8'h48);
        irq = 8'h08;
        cfg(2'd0, 8'h00);
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL t5_level_pending got=%h exp=08", pending); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t5_intr got=%b exp=1", intr); end
        ack(8'h4B);
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL t5_no_clear got=%h exp=08", pending); end
        tick();
        cfg(2'd3, 8'h00);
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t5_reassert got=%b exp=1", intr); end
        ack(8'h4B);
        irq = 8'h00;
        tick();
        cfg(2'd3, 8'h00);
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL t5_level_drop got=%h exp=00", pending); end
    endtask

    task automatic test_reset_mid();
        irq = 8'h04;
        tick(); tick();
        ack(8'h4A);
        tick();
        irq = 8'h06;
        tick(); tick();
        checks++; if (intr !== 1'b1 || in_service !== 8'h04) begin
            errors++; $display("FAIL t6_setup got=%b/%h exp=1/04", intr, in_service);
        end
        reset = 1'b1;
        #1;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t6_intr got=%b exp=0", intr); end
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL t6_is got=%h exp=00", in_service); end
        checks++; if (pending !== 8'h00 || vector !== 8'h00) begin
            errors++; $display("FAIL t6_pend_vec got=%h/%h exp=00/00", pending, vector);
        end
        irq = 8'h02;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL t6_edge_default got=%h exp=02", pending); end
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t6_mask_default got=%b exp=0", intr); end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL t6_inta_ignored got=%b exp=0", vector_valid); end
        tick(); tick();
        irq = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_nesting();
        test_spurious();
        test_level();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
